// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter : prescaled 0..9999 up-counter with binary + BCD outputs
// Revision 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run_on,
  input  logic        i_clr_on,
  output logic [13:0] o_count,
  output logic [3:0]  o_digit_1,
  output logic [3:0]  o_digit_10,
  output logic [3:0]  o_digit_100,
  output logic [3:0]  o_digit_1000,
  output logic        o_tick,
  output logic        o_wrap
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [13:0]        COUNT_MAX  = 14'd9999;

  generate
    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_div_check
      $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [13:0]        count_q, count_d;
  logic [3:0]         d1_q, d1_d, d10_q, d10_d, d100_q, d100_d, d1000_q, d1000_d;
  logic               tick_q, tick_d, wrap_q, wrap_d;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    d1_d    = d1_q;
    d10_d   = d10_q;
    d100_d  = d100_q;
    d1000_d = d1000_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (i_clr_on) begin
      presc_d = '0;
      count_d = '0;
      d1_d    = '0;
      d10_d   = '0;
      d100_d  = '0;
      d1000_d = '0;
    end else if (i_run_on) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        wrap_d  = (count_q == COUNT_MAX);
        count_d = (count_q == COUNT_MAX) ? 14'd0 : count_q + 14'd1;
        // Decade cascade: 9999 rolls every digit to 0 in lock-step with count.
        d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
        if (d1_q == 4'd9) begin
          d10_d = (d10_q == 4'd9) ? 4'd0 : d10_q + 4'd1;
          if (d10_q == 4'd9) begin
            d100_d = (d100_q == 4'd9) ? 4'd0 : d100_q + 4'd1;
            if (d100_q == 4'd9) begin
              d1000_d = (d1000_q == 4'd9) ? 4'd0 : d1000_q + 4'd1;
            end
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
      d1_q    <= '0;
      d10_q   <= '0;
      d100_q  <= '0;
      d1000_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      d1_q    <= d1_d;
      d10_q   <= d10_d;
      d100_q  <= d100_d;
      d1000_q <= d1000_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count      = count_q;
  assign o_digit_1    = d1_q;
  assign o_digit_10   = d10_q;
  assign o_digit_100  = d100_q;
  assign o_digit_1000 = d1000_q;
  assign o_tick       = tick_q;
  assign o_wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter : DIV=10 and DIV=2 instances against an accumulated-time model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [2];
  logic        run_v [2];
  logic        clr_v [2];
  logic [13:0] cnt   [2];
  logic [3:0]  dg1   [2];
  logic [3:0]  dg10  [2];
  logic [3:0]  dg100 [2];
  logic [3:0]  dg1000[2];
  logic        tck   [2];
  logic        wrp   [2];

  stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(1)) u_dut10 (
    .clk(clk), .reset(rst_v[0]), .i_run_on(run_v[0]), .i_clr_on(clr_v[0]),
    .o_count(cnt[0]), .o_digit_1(dg1[0]), .o_digit_10(dg10[0]),
    .o_digit_100(dg100[0]), .o_digit_1000(dg1000[0]),
    .o_tick(tck[0]), .o_wrap(wrp[0])
  );

  stopwatch_counter #(.CLK_HZ(2), .TICK_HZ(1)) u_dut2 (
    .clk(clk), .reset(rst_v[1]), .i_run_on(run_v[1]), .i_clr_on(clr_v[1]),
    .o_count(cnt[1]), .o_digit_1(dg1[1]), .o_digit_10(dg10[1]),
    .o_digit_100(dg100[1]), .o_digit_1000(dg1000[1]),
    .o_tick(tck[1]), .o_wrap(wrp[1])
  );

  // Model: total run-edges accumulated modulo 10000*DIV; everything derives from it.
  int div_c [2];
  int acc   [2];
  bit exp_tick [2];
  bit exp_wrap [2];
  int model_incs [2];
  int dut_ticks  [2];
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  initial begin
    div_c[0] = 10;
    div_c[1] = 2;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0; exp_tick[k] = 0; exp_wrap[k] = 0;
      model_incs[k] = 0; dut_ticks[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_tick[k] = 1'b0;
      exp_wrap[k] = 1'b0;
      if (rst_v[k] || clr_v[k]) begin
        acc[k] = 0;
      end else if (run_v[k]) begin
        acc[k] = (acc[k] + 1) % (10000 * div_c[k]);
        if (acc[k] % div_c[k] == 0) begin
          exp_tick[k] = 1'b1;
          model_incs[k]++;
        end
        exp_wrap[k] = (acc[k] == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        bit bad;
        c = acc[k] / div_c[k];
        bad = (int'(cnt[k]) != c) ||
              (int'(dg1[k]) != c % 10) || (int'(dg10[k]) != (c / 10) % 10) ||
              (int'(dg100[k]) != (c / 100) % 10) || (int'(dg1000[k]) != c / 1000) ||
              (tck[k] != exp_tick[k]) || (wrp[k] != exp_wrap[k]) ||
              (int'(cnt[k]) != 1000*dg1000[k] + 100*dg100[k] + 10*dg10[k] + dg1[k]);
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL cycle_dut%0d t=%0t: got count=%0d digits=%0d%0d%0d%0d tick=%0b wrap=%0b, want count=%0d tick=%0b wrap=%0b",
                   k, $time, cnt[k], dg1000[k], dg100[k], dg10[k], dg1[k], tck[k], wrp[k],
                   c, exp_tick[k], exp_wrap[k]);
        end
        if (tck[k] === 1'b1) dut_ticks[k]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic reset_all();
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; run_v[k] = 1'b0; clr_v[k] = 1'b0;
    end
    step(1);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
  endtask

  int t0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; run_v[k] = 1'b0; clr_v[k] = 1'b0;
    end
    step(2);
    checking = 1'b1;
    chk("reset_count", int'(cnt[0]), 0);
    chk("reset_tick_wrap", int'({tck[0], wrp[0], tck[1], wrp[1]}), 0);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // 35 run edges at DIV=10
    run_v[0] = 1'b1;
    step(35);
    chk("run35_count", int'(cnt[0]), 3);
    chk("run35_digits", int'({dg1000[0], dg100[0], dg10[0], dg1[0]}), 16'h0003);
    chk("run35_presc_model", acc[0] % 10, 5);
    #4;
    chk("run35_ticks", dut_ticks[0], 3);

    // Pause keeps the partial prescale
    reset_all();
    t0 = dut_ticks[0];
    run_v[0] = 1'b1; step(7);
    run_v[0] = 1'b0; step(50);
    chk("pause_count", int'(cnt[0]), 0);
    #4;
    chk("pause_no_tick", dut_ticks[0], t0);
    run_v[0] = 1'b1; step(3);
    chk("pause_resume_count", int'(cnt[0]), 1);
    chk("pause_resume_tick", int'(tck[0]), 1);

    // Clear on a terminal prescale edge wins
    reset_all();
    run_v[0] = 1'b1; step(420);
    chk("clr_pre_count", int'(cnt[0]), 42);
    step(9);
    chk("clr_terminal_count", int'(cnt[0]), 42);
    clr_v[0] = 1'b1; step(1);
    chk("clr_count", int'(cnt[0]), 0);
    chk("clr_no_tick_wrap", int'({tck[0], wrp[0]}), 0);
    clr_v[0] = 1'b0; step(9);
    chk("clr_release_9", int'(cnt[0]), 0);
    step(1);
    chk("clr_release_10", int'(cnt[0]), 1);

    // Reset mid-count
    reset_all();
    run_v[0] = 1'b1; step(12346);
    chk("mid_count", int'(cnt[0]), 1234);
    chk("mid_digits", int'({dg1000[0], dg100[0], dg10[0], dg1[0]}), 16'h1234);
    chk("mid_presc_model", acc[0] % 10, 6);
    rst_v[0] = 1'b1; step(1);
    chk("mid_reset_count", int'(cnt[0]), 0);
    rst_v[0] = 1'b0; step(9);
    chk("mid_resume_9", int'(cnt[0]), 0);
    step(1);
    chk("mid_resume_10", int'(cnt[0]), 1);

    // Carries and full wrap at DIV=2
    reset_all();
    run_v[1] = 1'b1; step(198);
    chk("c0099", int'({dg1000[1], dg100[1], dg10[1], dg1[1]}), 16'h0099);
    step(2);
    chk("c0100", int'({dg1000[1], dg100[1], dg10[1], dg1[1]}), 16'h0100);
    step(1798);
    chk("c0999", int'({dg1000[1], dg100[1], dg10[1], dg1[1]}), 16'h0999);
    step(2);
    chk("c1000", int'({dg1000[1], dg100[1], dg10[1], dg1[1]}), 16'h1000);
    step(17998);
    chk("c9999", int'({dg1000[1], dg100[1], dg10[1], dg1[1]}), 16'h9999);
    step(1);
    chk("pre_wrap_flags", int'({tck[1], wrp[1]}), 0);
    step(1);
    chk("wrap_count", int'(cnt[1]), 0);
    chk("wrap_flags", int'({tck[1], wrp[1]}), 3);
    step(1);
    chk("post_wrap_flags", int'({tck[1], wrp[1]}), 0);

    // Random run/clear/reset toggling on both instances
    for (int i = 0; i < 30000; i++) begin
      for (int k = 0; k < 2; k++) begin
        run_v[k] = ($urandom % 4) != 0;
        clr_v[k] = ($urandom % 64) == 0;
        rst_v[k] = ($urandom % 512) == 0;
      end
      step(1);
    end
    for (int k = 0; k < 2; k++) begin
      run_v[k] = 1'b0; clr_v[k] = 1'b0; rst_v[k] = 1'b0;
    end
    step(2);
    #4;
    chk("ticks_vs_incs_dut10", dut_ticks[0], model_incs[0]);
    chk("ticks_vs_incs_dut2", dut_ticks[1], model_incs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
